// File: rtl/watch_pkg.sv
// Shared state encoding and field-select codes for the watch set control unit.
// WATCH_SET_SEC_EN adds the seconds-edit state to the mode sequence.
package watch_pkg;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  typedef enum logic [1:0] {
    StNormal  = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StSetSec  = 2'd3
  } state_e;

  function automatic state_e next_state(state_e s);
    state_e n;
    n = StNormal;
    case (s)
      StNormal:  n = StSetHour;
      StSetHour: n = StSetMin;
`ifdef WATCH_SET_SEC_EN
      StSetMin:  n = StSetSec;
`else
      StSetMin:  n = StNormal;
`endif
      default:   n = StNormal;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] sel_of(state_e s);
    logic [1:0] sel;
    sel = SEL_NONE;
    case (s)
      StSetHour: sel = SEL_HOUR;
      StSetMin:  sel = SEL_MIN;
      StSetSec:  sel = SEL_SEC;
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/watch_set_cu_if.sv
// Button/timebase inputs and datapath control outputs of the watch set control unit.
interface watch_set_cu_if;
  logic       i_tick;
  logic       i_mode;
  logic       i_up;
  logic       i_down;
  logic [1:0] o_sel;
  logic       o_inc;
  logic       o_dec;
  logic       o_hold;
  logic       o_blink;

  modport master (
    output i_tick, i_mode, i_up, i_down,
    input  o_sel, o_inc, o_dec, o_hold, o_blink
  );

  modport slave (
    input  i_tick, i_mode, i_up, i_down,
    output o_sel, o_inc, o_dec, o_hold, o_blink
  );
endinterface

// File: rtl/tick_cnt.sv
// Clearable counter advanced by i_tick; o_term flags the tick that reaches MAX and wraps to 0.
module tick_cnt #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_tick,
  output logic o_term
);
  localparam int unsigned W = $clog2(MAX + 1);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_cnt;
  logic         w_term;

  // A clear in the same cycle suppresses the terminal flag.
  assign w_term = i_tick & ~i_clr & (r_cnt == LAST);
  assign o_term = w_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_term ? '0 : r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/watch_set_cu.sv
// Watch time-set control unit: mode sequencing, inc/dec pulses, idle timeout and field blink.
// Seconds editing is present only when WATCH_SET_SEC_EN is defined (see watch_pkg).
module watch_set_cu
  import watch_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 1000,
  parameter int unsigned BLINK_TICKS   = 50
) (
  input  logic           clk,
  input  logic           rst,
  watch_set_cu_if.slave  bus
);
  state_e     r_state;
  logic [1:0] r_sel;
  logic       r_inc;
  logic       r_dec;
  logic       r_hold;
  logic       r_blink;

  logic   w_normal;
  logic   w_act;
  logic   w_idle_term;
  logic   w_blink_term;
  logic   w_idle_clr;
  logic   w_blink_clr;
  state_e w_next;

  assign w_normal    = (r_state == StNormal);
  assign w_act       = bus.i_mode | bus.i_up | bus.i_down;
  assign w_next      = next_state(r_state);
  assign w_idle_clr  = w_normal | w_act;
  assign w_blink_clr = w_normal | w_act | w_idle_term;

  tick_cnt #(
    .MAX (TIMEOUT_TICKS)
  ) u_idle_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_idle_clr),
    .i_tick (bus.i_tick),
    .o_term (w_idle_term)
  );

  tick_cnt #(
    .MAX (BLINK_TICKS)
  ) u_blink_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_blink_clr),
    .i_tick (bus.i_tick),
    .o_term (w_blink_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StNormal;
      r_sel   <= SEL_NONE;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_hold  <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      if (bus.i_mode) begin
        // Mode wins over up/down; entering a set state shows the field immediately.
        r_state <= w_next;
        r_sel   <= sel_of(w_next);
        r_hold  <= (w_next != StNormal);
        r_blink <= (w_next != StNormal);
      end else if (w_normal) begin
        r_blink <= 1'b0;
      end else if (w_act) begin
        r_inc   <= bus.i_up & ~bus.i_down;
        r_dec   <= bus.i_down & ~bus.i_up;
        r_blink <= 1'b1;
      end else if (w_idle_term) begin
        r_state <= StNormal;
        r_sel   <= SEL_NONE;
        r_hold  <= 1'b0;
        r_blink <= 1'b0;
      end else if (w_blink_term) begin
        r_blink <= ~r_blink;
      end
    end
  end

  assign bus.o_sel   = r_sel;
  assign bus.o_inc   = r_inc;
  assign bus.o_dec   = r_dec;
  assign bus.o_hold  = r_hold;
  assign bus.o_blink = r_blink;
endmodule

// File: doc/watch_set_cu.md
WATCH_SET_CU -- requirements
Module: watch_set_cu

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 1000, i_tick pulses of button inactivity before leaving set mode (>=1).
REQ-002 SHALL have parameter BLINK_TICKS, default 50, i_tick pulses per o_blink half-period (>=1).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_tick  input  1  single-cycle timebase pulse (100 Hz nominal).
REQ-006 SHALL have port i_mode  input  1  single-cycle debounced mode-button pulse.
REQ-007 SHALL have port i_up  input  1  single-cycle debounced up-button pulse.
REQ-008 SHALL have port i_down  input  1  single-cycle debounced down-button pulse.
REQ-009 SHALL have port o_sel  output  2  field select to time datapath: 0 none, 1 hour, 2 min, 3 sec.
REQ-010 SHALL have port o_inc  output  1  single-cycle increment pulse for selected field.
REQ-011 SHALL have port o_dec  output  1  single-cycle decrement pulse for selected field.
REQ-012 SHALL have port o_hold  output  1  freezes datapath timekeeping while high.
REQ-013 SHALL have port o_blink  output  1  display blank/show control for selected field.

Function
REQ-014 SHALL implement FSM states NORMAL, SET_HOUR, SET_MIN, SET_SEC; all outputs registered.
REQ-015 SHALL advance on i_mode: NORMAL->SET_HOUR->SET_MIN->SET_SEC->NORMAL; new state visible on o_sel one cycle after the i_mode cycle.
REQ-016 SHALL drive o_sel 0 in NORMAL, 1/2/3 in SET_HOUR/SET_MIN/SET_SEC; o_hold = 1 in every set state, 0 in NORMAL.
REQ-017 SHALL, in a set state, assert o_inc (o_dec) for exactly one cycle, the cycle after i_up (i_down) is sampled; in NORMAL i_up/i_down are ignored.
REQ-018 SHALL give i_mode priority: i_mode together with i_up or i_down -> state advance only, no o_inc/o_dec.
REQ-019 SHALL ignore i_up and i_down asserted in the same cycle (no pulse), but treat it as activity for REQ-020.
REQ-020 SHALL keep an idle counter in set states: cleared on entry and on any button pulse, incremented per i_tick; on reaching TIMEOUT_TICKS go to NORMAL next cycle.
REQ-021 SHALL let a button pulse win over a coincident timeout: counter clears, no return to NORMAL.
REQ-022 SHALL toggle o_blink every BLINK_TICKS i_tick pulses in set states; blink counter wraps to 0 on toggle.
REQ-023 SHALL force o_blink = 1 and clear blink counter on set-state entry and on every i_up/i_down, so the edited field is shown.
REQ-024 SHALL hold o_blink = 0 and both counters at 0 in NORMAL.
REQ-025 SHALL size counters as $clog2(param+1) bits; no wrap beyond parameter value.

Reset
REQ-026 SHALL, on rst, immediately enter NORMAL with o_sel=0, o_inc=0, o_dec=0, o_hold=0, o_blink=0, counters 0, including mid-edit.

Configuration
REQ-027 SHALL, with macro WATCH_SET_SEC_EN defined, include SET_SEC per REQ-015.
REQ-028 SHALL, without WATCH_SET_SEC_EN, omit SET_SEC: i_mode in SET_MIN -> NORMAL; o_sel never 3.

Structure
REQ-029 SHALL take state encoding and o_sel codes (SEL_NONE/HOUR/MIN/SEC) from shared package watch_pkg.
REQ-030 SHALL instantiate sub-module tick_cnt (clearable, i_tick-enabled counter with terminal flag) twice: idle timeout and blink.

Verification (bench: TIMEOUT_TICKS=5, BLINK_TICKS=2, WATCH_SET_SEC_EN defined unless noted)
REQ-031 SHALL cover: 4 i_mode pulses from reset -> o_sel 1,2,3,0, o_hold high during 1..3 then 0.
REQ-032 SHALL cover: SET_MIN, i_up, then i_down -> one o_inc then one o_dec pulse, each one cycle after the input; i_up in NORMAL -> no pulse.
REQ-033 SHALL cover: SET_HOUR, 5 i_tick without buttons -> o_sel 0 one cycle after 5th tick; i_up on 5th tick instead -> remains o_sel 1.
REQ-034 SHALL cover: SET_HOUR, ticks -> o_blink 1,1,0,0,1 pattern per tick pair; i_down mid-low phase -> o_blink 1 next cycle.
REQ-035 SHALL cover: i_mode+i_up together -> advance, no o_inc; i_up+i_down together -> no pulse, idle counter cleared.
REQ-036 SHALL cover: rst asserted in SET_MIN -> all outputs 0 asynchronously; macro undefined -> 3 i_mode pulses return o_sel to 0.
